// File: rtl/reset_seq_pkg.sv
// Shared definitions for the staged reset sequencer: state encoding, stage
// count and the stage-select helper.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } seq_state_e;

  localparam int unsigned NUM_STAGES = 3;
  localparam logic [1:0]  LAST_IDX   = 2'(NUM_STAGES - 1);

  // One-hot release mask for stage idx; indices past the last stage give zero.
  function automatic logic [NUM_STAGES-1:0] stage_bit(input logic [1:0] idx);
    logic [NUM_STAGES-1:0] m;
    m = '0;
    for (int i = 0; i < int'(NUM_STAGES); i++) begin
      if (idx == 2'(i)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/reset_filter.sv
// Two-flop synchronizer plus glitch filter for the external active-low reset pin.
// The filtered level only flips after FILTER_LEN consecutive opposing samples.
module reset_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ext_resetb,
  output logic filt_resetb
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic             sync0_q;
  logic             sync1_q;
  logic             filt_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync0_q <= ext_resetb;
      sync1_q <= sync0_q;
      // Any sample agreeing with the current level restarts the run count.
      if (sync1_q == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_q <= sync1_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign filt_resetb = filt_q;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: releases three active-low resets in order, each after
// cfg_delay+1 cycles, with soft and external reset re-entry.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int DELAY_W    = 8,
  parameter int FILTER_LEN = 4
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               ext_resetb,
  input  logic               soft_req,
  input  logic [DELAY_W-1:0] cfg_delay,
  output logic [2:0]         rstn_out,
  output logic               soft_ack,
  output logic               seq_busy,
  output logic               done
);

  logic [1:0]         rst_sync_q;
  logic               rst_n_int;
  logic               filt_resetb;
  seq_state_e         state_q;
  logic [1:0]         idx_q;
  logic [DELAY_W-1:0] cnt_q;
  logic [2:0]         rstn_q;
  logic               ack_q;
  logic               busy_q;
  logic               done_q;

  // Assert asynchronously, release two edges after resetb rises.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_int = rst_sync_q[1];

  reset_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk         (clk),
    .rst_n       (rst_n_int),
    .ext_resetb  (ext_resetb),
    .filt_resetb (filt_resetb)
  );

  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q <= HOLD;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      rstn_q  <= 3'b000;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      // Filtered external reset overrides everything, including soft_req.
      if (!filt_resetb) begin
        state_q <= HOLD;
        idx_q   <= 2'd0;
        cnt_q   <= cfg_delay;
        rstn_q  <= 3'b000;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        case (state_q)
          HOLD: begin
            rstn_q  <= 3'b000;
            cnt_q   <= cfg_delay;
            idx_q   <= 2'd0;
            state_q <= WAIT;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
          WAIT: begin
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - DELAY_W'(1);
            end else begin
              rstn_q <= rstn_q | stage_bit(idx_q);
              cnt_q  <= cfg_delay;
              if (idx_q == LAST_IDX) begin
                state_q <= RUN;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else begin
                idx_q <= idx_q + 2'd1;
              end
            end
          end
          RUN: begin
            if (soft_req) begin
              state_q <= HOLD;
              rstn_q  <= 3'b000;
              ack_q   <= 1'b1;
              done_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= HOLD;
            rstn_q  <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rstn_out = rstn_q;
  assign soft_ack = ack_q;
  assign seq_busy = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with a per-cycle expected-output queue.
module tb_reset_sequencer;

  logic       clk;
  logic       resetb;
  logic       ext_resetb;
  logic       soft_req;
  logic [7:0] cfg_delay;
  logic [2:0] rstn_out;
  logic       soft_ack;
  logic       seq_busy;
  logic       done;

  typedef struct {
    logic [2:0] rstn;
    logic       busy;
    logic       dn;
    logic       ack;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  reset_sequencer #(
    .DELAY_W    (8),
    .FILTER_LEN (4)
  ) dut (
    .clk        (clk),
    .resetb     (resetb),
    .ext_resetb (ext_resetb),
    .soft_req   (soft_req),
    .cfg_delay  (cfg_delay),
    .rstn_out   (rstn_out),
    .soft_ack   (soft_ack),
    .seq_busy   (seq_busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input int lim);
    int n;
    n = 0;
    while (seq_busy !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk("busy_rise", 3'(seq_busy), 3'd1);
    chk("exit_rstn", rstn_out, 3'b000);
    chk("exit_done", 3'(done), 3'd0);
    chk("exit_ack", 3'(soft_ack), 3'd0);
  endtask

  // Called on the cycle the sequencer has just left HOLD; checks ncyc edges.
  task automatic run_seq(input int d, input int soft_at, input int ncyc);
    exp_t e;
    for (int k = 1; k <= ncyc; k++) begin
      e.rstn = 3'b000;
      for (int s = 0; s < 3; s++) begin
        if ((s + 1) * (d + 1) <= k) e.rstn[s] = 1'b1;
      end
      e.busy = (k < 3 * (d + 1));
      e.dn   = !(k < 3 * (d + 1));
      e.ack  = 1'b0;
      sb.push_back(e);
    end
    for (int k = 1; k <= ncyc; k++) begin
      if (k == soft_at) soft_req = 1'b1;
      tick();
      soft_req = 1'b0;
      e = sb.pop_front();
      chk("seq_rstn", rstn_out, e.rstn);
      chk("seq_busy", 3'(seq_busy), 3'(e.busy));
      chk("seq_done", 3'(done), 3'(e.dn));
      chk("seq_ack", 3'(soft_ack), 3'(e.ack));
    end
  endtask

  initial begin
    resetb     = 1'b0;
    ext_resetb = 1'b1;
    soft_req   = 1'b0;
    cfg_delay  = 8'd3;

    repeat (5) tick();
    chk("rst_rstn", rstn_out, 3'b000);
    chk("rst_ack", 3'(soft_ack), 3'd0);
    chk("rst_busy", 3'(seq_busy), 3'd0);
    chk("rst_done", 3'(done), 3'd0);

    // Power-up with D=3: stages at 4, 8, 12 edges after HOLD exit.
    resetb = 1'b1;
    tick();
    chk("sync1_busy", 3'(seq_busy), 3'd0);
    tick();
    chk("sync2_busy", 3'(seq_busy), 3'd0);
    wait_busy(40);
    run_seq(3, 0, 12);

    // Three-cycle glitch must be filtered out.
    ext_resetb = 1'b0;
    repeat (3) tick();
    ext_resetb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("glitch_rstn", rstn_out, 3'b111);
      chk("glitch_done", 3'(done), 3'd1);
    end

    // Long external reset returns to HOLD.
    ext_resetb = 1'b0;
    repeat (10) tick();
    chk("ext_rstn", rstn_out, 3'b000);
    chk("ext_done", 3'(done), 3'd0);
    chk("ext_busy", 3'(seq_busy), 3'd0);
    ext_resetb = 1'b1;
    wait_busy(40);
    run_seq(3, 0, 12);

    // Soft reset in RUN, re-sequence with new delay.
    cfg_delay = 8'd2;
    soft_req  = 1'b1;
    tick();
    soft_req = 1'b0;
    chk("soft_ack", 3'(soft_ack), 3'd1);
    chk("soft_rstn", rstn_out, 3'b000);
    chk("soft_done", 3'(done), 3'd0);
    chk("soft_busy", 3'(seq_busy), 3'd0);
    wait_busy(40);
    run_seq(2, 0, 9);

    // soft_req during WAIT is ignored.
    cfg_delay = 8'd3;
    soft_req  = 1'b1;
    tick();
    soft_req = 1'b0;
    chk("soft2_ack", 3'(soft_ack), 3'd1);
    wait_busy(40);
    run_seq(3, 2, 12);

    // soft_req on the edge the filtered reset goes active: no ack.
    ext_resetb = 1'b0;
    repeat (6) tick();
    chk("coll_pre_done", 3'(done), 3'd1);
    soft_req = 1'b1;
    tick();
    soft_req = 1'b0;
    chk("coll_ack", 3'(soft_ack), 3'd0);
    chk("coll_rstn", rstn_out, 3'b000);
    chk("coll_done", 3'(done), 3'd0);
    tick();
    chk("coll_ack2", 3'(soft_ack), 3'd0);

    // Zero delay: one stage per edge, busy for three cycles.
    cfg_delay  = 8'd0;
    ext_resetb = 1'b1;
    wait_busy(40);
    run_seq(0, 0, 3);

    // Mid-sequence power-on reset clears outputs immediately.
    cfg_delay = 8'd10;
    soft_req  = 1'b1;
    tick();
    soft_req = 1'b0;
    chk("mid_ack", 3'(soft_ack), 3'd1);
    wait_busy(40);
    run_seq(10, 0, 11);
    #2 resetb = 1'b0;
    #1;
    chk("async_rstn", rstn_out, 3'b000);
    chk("async_busy", 3'(seq_busy), 3'd0);
    chk("async_done", 3'(done), 3'd0);
    chk("async_ack", 3'(soft_ack), 3'd0);
    repeat (3) tick();
    resetb = 1'b1;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
